riscv_test_monitor: RTL
=======================

Name: riscv_test_monitor

Overview:
- Parametrised, synthesizable pass/fail monitor for riscv-tests runs on one or more pipelined cores.
- Snoops each core's data-memory store port for writes to the tohost address and decodes the riscv-tests exit code.
- Counts cycles and retired instructions, and enforces a cycle timeout.
- Drives registered done/pass/timeout status, so benches and FPGA LEDs no longer rely on a fixed-delay finish.

Parameters:
- NUM_CH, 1: number of monitored cores (channels), 1..8.
- ADDR_W, 32: store address width.
- TOHOST_ADDR, 32'h0000_1000: byte address of tohost.
- TIMEOUT_CYCLES, 500: run cycles before timeout; 0 disables timeout.
- CNT_W, 32: width of cycle and retire counters.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- ch_mem_we  in  NUM_CH  per-channel store strobe, one cycle per store.
- ch_mem_addr  in  NUM_CH*ADDR_W  per-channel store address; channel i at bits [i*ADDR_W +: ADDR_W].
- ch_mem_wdata  in  NUM_CH*32  per-channel store data.
- ch_retire  in  NUM_CH  per-channel instruction-retired pulse.
- done  out  1  run finished: all channels terminated, or timeout.
- pass  out  1  done and no channel failed and no timeout.
- timeout  out  1  timeout occurred (sticky).
- fail_mask  out  NUM_CH  per-channel failed flag.
- fail_testnum  out  31  test number of lowest-index failing channel; 0 if none.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retire_count  out  NUM_CH*CNT_W  per-channel retired instructions.

Behaviour:
- Reset (async assert, sync release): all outputs 0; every channel in CH_RUN; global state RUN.
- Tohost hit on channel i: ch_mem_we[i]=1 and ch_mem_addr[i]==TOHOST_ADDR, sampled at a rising edge.
- Per-channel FSM, states CH_RUN, CH_PASS, CH_FAIL:
  - CH_RUN -> CH_PASS: hit with wdata==1.
  - CH_RUN -> CH_FAIL: hit with wdata[0]==1 and wdata[31:1]!=0; fail_mask[i] set at the same edge.
  - Hit with wdata even (including 0) is ignored; channel stays in CH_RUN.
  - CH_PASS and CH_FAIL are terminal; later hits are ignored.
  - A channel leaves a terminal state only on reset.
- fail_testnum:
  - Tracks the lowest-index channel in CH_FAIL and holds that channel's wdata[31:1].
  - If a lower-index channel fails later, fail_testnum updates to its value.
- Global FSM, states RUN, DONE, TIMEOUT:
  - RUN -> DONE: at the edge after the edge where the last channel became terminal. Latency from the final hit to done=1 is 2 edges.
  - RUN -> TIMEOUT: when TIMEOUT_CYCLES!=0, cycle_count==TIMEOUT_CYCLES-1, and not all channels are terminal (including after this edge's hits).
  - DONE and TIMEOUT are absorbing until reset.
- Priority: a final hit and the timeout condition at the same edge resolve as completion; timeout is not set.
- done: 1 in DONE or TIMEOUT.
- timeout: 1 only in TIMEOUT.
- pass: 1 only in DONE with fail_mask==0; in TIMEOUT pass=0 even if some channels passed.
- cycle_count:
  - Increments every edge in RUN and freezes on leaving RUN.
  - Saturates at all-ones; no wrap.
- retire_count[i]:
  - Increments on ch_retire[i] while channel i is in CH_RUN and the global state is RUN.
  - Saturating; freezes once the channel is terminal or on timeout.
  - A retire pulse on the same edge as the terminating hit is still counted.
- Simultaneous hits on several channels at one edge are all captured independently.
- Reset mid-run clears everything immediately (asynchronous); monitoring restarts on release.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- NUM_CH=1: after 40 cycles, store 1 to 0x1000 -> done=1 and pass=1 two edges later; cycle_count frozen at 41; timeout=0.
- NUM_CH=1: store 0x0000_0007 to 0x1000 -> fail_mask=1, fail_testnum=3, done=1, pass=0. A following store of 1 changes nothing.
- NUM_CH=1: stores of 0 and 2 to 0x1000, and store of 1 to 0x1004 -> all ignored. With TIMEOUT_CYCLES=100, timeout=1 and done=1 after cycle 100; pass=0; cycle_count=100.
- NUM_CH=2: ch0 stores 1 at cycle 10; ch1 stores 0xB at cycle 20 -> done only after ch1's hit; fail_mask=2'b10; fail_testnum=5; pass=0; ch0's retire_count frozen from cycle 10.
- NUM_CH=1, TIMEOUT_CYCLES=50: store 1 at the edge where cycle_count==49 -> done=1, pass=1, timeout=0 (completion wins).
- Assert sys_rst_n low mid-run, asynchronously between edges -> all outputs 0 immediately; after release, a store of 1 gives pass=1 with a fresh cycle_count.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// riscv-tests pass/fail monitor: snoops tohost stores per core,
// tracks exit codes, counts cycles/retires and enforces a timeout.
module riscv_test_monitor #(
    parameter int                NUM_CH         = 1,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter int                TIMEOUT_CYCLES = 500,
    parameter int                CNT_W          = 32
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_CH-1:0]       ch_mem_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_mem_addr,
    input  logic [NUM_CH*32-1:0]    ch_mem_wdata,
    input  logic [NUM_CH-1:0]       ch_retire,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [NUM_CH-1:0]       fail_mask,
    output logic [30:0]             fail_testnum,
    output logic [CNT_W-1:0]        cycle_count,
    output logic [NUM_CH*CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {CH_RUN, CH_PASS, CH_FAIL} ch_state_t;
    typedef enum logic [1:0] {RUN, DONE, TIMEOUT} g_state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ch_state_t   ch_state [NUM_CH];
    ch_state_t   ch_next  [NUM_CH];
    logic [30:0] code_q   [NUM_CH];
    logic [30:0] code_d   [NUM_CH];
    g_state_t    g_state, g_next;
    logic        all_term, all_term_next;
    logic [NUM_CH-1:0] fail_d;
    logic [30:0] testnum_d;

    // Walk channels high-to-low so the lowest failing index wins.
    always_comb begin
        all_term      = 1'b1;
        all_term_next = 1'b1;
        fail_d        = '0;
        testnum_d     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            ch_next[i] = ch_state[i];
            code_d[i]  = code_q[i];
            if (g_state == RUN && ch_state[i] == CH_RUN &&
                ch_mem_we[i] &&
                ch_mem_addr[i*ADDR_W +: ADDR_W] == TOHOST_ADDR) begin
                if (ch_mem_wdata[i*32 +: 32] == 32'd1) begin
                    ch_next[i] = CH_PASS;
                end else if (ch_mem_wdata[i*32]) begin
                    ch_next[i] = CH_FAIL;
                    code_d[i]  = ch_mem_wdata[i*32+1 +: 31];
                end
            end
            if (ch_state[i] == CH_RUN) all_term = 1'b0;
            if (ch_next[i] == CH_RUN) all_term_next = 1'b0;
            if (ch_next[i] == CH_FAIL) begin
                fail_d[i] = 1'b1;
                testnum_d = code_d[i];
            end
        end
    end

    // Completion beats timeout when both land on the same edge.
    always_comb begin
        g_next = g_state;
        unique case (g_state)
            RUN: begin
                if (all_term)
                    g_next = DONE;
                else if (TIMEOUT_CYCLES != 0 && cycle_count == TO_LAST &&
                         !all_term_next)
                    g_next = TIMEOUT;
            end
            default: g_next = g_state;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            g_state      <= RUN;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            fail_mask    <= '0;
            fail_testnum <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state[i] <= CH_RUN;
                code_q[i]   <= '0;
            end
        end else begin
            g_state      <= g_next;
            done         <= (g_next != RUN);
            timeout      <= (g_next == TIMEOUT);
            pass         <= (g_next == DONE) && (fail_d == '0);
            fail_mask    <= fail_d;
            fail_testnum <= testnum_d;
            if (g_state == RUN && cycle_count != '1)
                cycle_count <= cycle_count + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state[i] <= ch_next[i];
                code_q[i]   <= code_d[i];
                if (ch_retire[i] && g_state == RUN &&
                    ch_state[i] == CH_RUN &&
                    retire_count[i*CNT_W +: CNT_W] != '1)
                    retire_count[i*CNT_W +: CNT_W] <=
                        retire_count[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

endmodule
